alu_seq: RTL and testbench
==========================

# alu_seq

Parameterised, handshaked successor to the combinational 16-bit ALU. It registers operands and results and adds a valid/ready interface on both sides. Unsigned quotient and remainder use an iterative restoring divider, so a result can stall downstream. It also adds negative and divide-by-zero flags, variable-amount rotates, and true 0/1 set-less-than results. It sits between the operand/opcode issue logic and the writeback stage, with one operation in flight at a time.

## Interface
- WIDTH, 16: operand/result width. Must be a power of two and at least 4. SHW = $clog2(WIDTH) is the shift/rotate amount width.
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- opcode  in  5  operation select
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts the result
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- carry_out  out  1  carry/borrow from ADD, SUB, INC, DEC; 0 otherwise
- overflow  out  1  signed overflow from ADD, SUB; 0 otherwise
- negative  out  1  result[WIDTH-1]
- div_by_zero  out  1  QUOTIENT/REMAINDER issued with b == 0
- busy  out  1  state != IDLE

## Operation
- Opcode map:
  - 00000 ADD, 00001 SUB, 00010 MUL (low WIDTH bits), 00011 QUOTIENT, 00100 REMAINDER.
  - 00101 AND, 00110 OR, 00111 XOR, 01000 NAND, 01001 NOR, 01010 XNOR, 01011 NOT a, 01100 negate a.
  - 01101 SLL, 01110 SRL, 01111 SRA; the shift amount is b[SHW-1:0].
  - 10000 SLT (signed), 10001 SLTU; each gives 1 or 0 zero-extended to WIDTH.
  - 10010 INC, 10011 DEC.
  - 10100 ROTL, 10101 ROTR; the rotate amount is b[SHW-1:0], and amount 0 returns a.
  - 10110 PASS a, 10111 PASS b.
  - 11000 MULHU: see Configuration.
  - Any other opcode gives result 0.
- Arithmetic is unsigned except SLT, SRA and the overflow flag.
  - carry_out on SUB/DEC is the borrow bit of the WIDTH+1-bit difference.
- FSM states: IDLE, DIV, HOLD.
  - IDLE: in_ready = 1. On in_valid:
    - non-divide opcode, or divide with b == 0: compute the result, load the output registers, go to HOLD.
    - divide with b != 0: latch a, b and opcode, clear the remainder register and the count, go to DIV.
  - DIV: one restoring step per cycle, MSB first. After WIDTH steps, load the quotient or remainder (as selected by the latched opcode) plus flags, then go to HOLD.
  - HOLD: out_valid = 1. result and flags are held stable. When out_ready = 1, go to IDLE.
- in_ready is 0 in DIV and HOLD; a request presented then is ignored, not queued.
- Divide by zero: result 0, div_by_zero 1, zero 1; no DIV cycles.
- Output flags are registered with result and are valid only while out_valid = 1.

## Timing
- Reset values:
  - state IDLE.
  - in_ready 1 in the cycle after reset.
  - out_valid 0, busy 0.
  - result 0, zero 0, carry_out 0, overflow 0, negative 0, div_by_zero 0.
- Non-divide latency: accept at edge N, out_valid high from edge N+1.
- Divide latency: accept at edge N, DIV occupies N+1..N+WIDTH, out_valid high from edge N+WIDTH+1.
- Throughput: at best one operation per 2 cycles (accept, then HOLD/consume). No accept occurs in the same cycle as out_ready.
- out_ready held high in HOLD: out_valid drops after exactly one cycle. out_ready low: HOLD persists indefinitely.
- rst at any edge, including mid-DIV or in HOLD, has priority over everything. The in-flight operation is discarded and no result is emitted.
- in_valid with an X opcode while in_ready = 0 has no effect.

## Configuration
- ALU_SEQ_MULHI_EN defined: opcode 11000 (MULHU) returns bits [2*WIDTH-1:WIDTH] of the unsigned a*b, with single-cycle latency.
- Not defined: opcode 11000 behaves as an unused opcode (result 0, zero 1), and no 2*WIDTH-bit product logic is instantiated.
- All other behaviour is identical in both builds.

## Test plan
All with WIDTH = 16.
- ADD a=0x7FFF, b=0x0001 -> result 0x8000, overflow 1, negative 1, carry 0; out_valid one cycle after accept.
- QUOTIENT a=1000, b=7 -> 142, out_valid exactly 17 cycles after accept. REMAINDER with the same operands -> 6. in_ready is 0 throughout.
- QUOTIENT a=5, b=0 -> result 0, div_by_zero 1, zero 1; out_valid one cycle after accept.
- ROTL a=0x8001, b=4 -> 0x0018; SLT a=0xFFFF, b=0x0001 -> 0x0001.
- Backpressure and reset:
  - Hold out_ready low for 5 cycles: result and flags stay stable, in_ready stays 0, a new in_valid is ignored.
  - Release out_ready: out_valid drops next cycle.
  - Assert rst 8 cycles into a DIV: out_valid 0, busy 0, in_ready 1 after the reset edge, and no stale result appears.
- MULHU a=0xFFFF, b=0xFFFF:
  - With ALU_SEQ_MULHI_EN -> 0xFFFE.
  - Without it -> 0x0000, zero 1.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked, registered ALU with an iterative restoring divider (one op in flight).
// Optional MULHU (opcode 11000) is enabled by defining ALU_SEQ_MULHI_EN.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic             negative,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SHW-1:0]   CNT_ZERO = {SHW{1'b0}};
  localparam logic [SHW-1:0]   CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
  localparam logic [SHW-1:0]   CNT_LAST = {SHW{1'b1}};

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_MUL   = 5'b00010;
  localparam logic [4:0] OP_QUO   = 5'b00011;
  localparam logic [4:0] OP_REM   = 5'b00100;
  localparam logic [4:0] OP_AND   = 5'b00101;
  localparam logic [4:0] OP_OR    = 5'b00110;
  localparam logic [4:0] OP_XOR   = 5'b00111;
  localparam logic [4:0] OP_NAND  = 5'b01000;
  localparam logic [4:0] OP_NOR   = 5'b01001;
  localparam logic [4:0] OP_XNOR  = 5'b01010;
  localparam logic [4:0] OP_NOT   = 5'b01011;
  localparam logic [4:0] OP_NEG   = 5'b01100;
  localparam logic [4:0] OP_SLL   = 5'b01101;
  localparam logic [4:0] OP_SRL   = 5'b01110;
  localparam logic [4:0] OP_SRA   = 5'b01111;
  localparam logic [4:0] OP_SLT   = 5'b10000;
  localparam logic [4:0] OP_SLTU  = 5'b10001;
  localparam logic [4:0] OP_INC   = 5'b10010;
  localparam logic [4:0] OP_DEC   = 5'b10011;
  localparam logic [4:0] OP_ROTL  = 5'b10100;
  localparam logic [4:0] OP_ROTR  = 5'b10101;
  localparam logic [4:0] OP_PASSA = 5'b10110;
  localparam logic [4:0] OP_PASSB = 5'b10111;
  localparam logic [4:0] OP_MULHU = 5'b11000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state_r, state_nxt_s;

  logic             in_ready_r, out_valid_r, busy_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r, carry_r, ovf_r, neg_r, dbz_r;

  logic [WIDTH-1:0] dvd_r, dvs_r, rem_r;
  logic [4:0]       op_r;
  logic [SHW-1:0]   count_r;

  logic [SHW-1:0]   amt_s;
  logic [WIDTH:0]   sum_s, diff_s, inc_s, dec_s;
  logic [WIDTH-1:0] mul_lo_s, rotl_s, rotr_s, alu_res_s;
  logic             alu_carry_s, alu_ovf_s, alu_dbz_s;
  logic             is_div_s, div_start_s;

  logic [WIDTH:0]   rem_shift_s;
  logic [WIDTH-1:0] rem_sub_s, rem_next_s, quo_next_s, div_res_s;
  logic             step_ok_s;

  assign amt_s  = b[SHW-1:0];
  assign sum_s  = {1'b0, a} + {1'b0, b};
  assign diff_s = {1'b0, a} - {1'b0, b};
  assign inc_s  = {1'b0, a} + {ZERO_W, 1'b1};
  assign dec_s  = {1'b0, a} - {ZERO_W, 1'b1};

`ifdef ALU_SEQ_MULHI_EN
  logic [WIDTH-1:0] mulhi_s;
  assign {mulhi_s, mul_lo_s} = {ZERO_W, a} * {ZERO_W, b};
`else
  assign mul_lo_s = a * b;
`endif

  assign is_div_s    = (opcode == OP_QUO) || (opcode == OP_REM);
  assign div_start_s = is_div_s && (b != ZERO_W);

  // Rotates index the operand modulo WIDTH, so amount 0 returns a unchanged.
  always_comb begin
    rotl_s = ZERO_W;
    rotr_s = ZERO_W;
    for (int i = 0; i < WIDTH; i++) begin
      rotl_s[i] = a[SHW'(i) - amt_s];
      rotr_s[i] = a[SHW'(i) + amt_s];
    end
  end

  // Single-cycle result and flags for every opcode except a real divide.
  always_comb begin
    alu_res_s   = ZERO_W;
    alu_carry_s = 1'b0;
    alu_ovf_s   = 1'b0;
    alu_dbz_s   = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res_s   = sum_s[WIDTH-1:0];
        alu_carry_s = sum_s[WIDTH];
        alu_ovf_s   = (a[MSB] == b[MSB]) && (sum_s[MSB] != a[MSB]);
      end
      OP_SUB: begin
        alu_res_s   = diff_s[WIDTH-1:0];
        alu_carry_s = diff_s[WIDTH];
        alu_ovf_s   = (a[MSB] != b[MSB]) && (diff_s[MSB] != a[MSB]);
      end
      OP_MUL:   alu_res_s = mul_lo_s;
      OP_QUO,
      OP_REM:   alu_dbz_s = (b == ZERO_W);
      OP_AND:   alu_res_s = a & b;
      OP_OR:    alu_res_s = a | b;
      OP_XOR:   alu_res_s = a ^ b;
      OP_NAND:  alu_res_s = ~(a & b);
      OP_NOR:   alu_res_s = ~(a | b);
      OP_XNOR:  alu_res_s = ~(a ^ b);
      OP_NOT:   alu_res_s = ~a;
      OP_NEG:   alu_res_s = ZERO_W - a;
      OP_SLL:   alu_res_s = a << amt_s;
      OP_SRL:   alu_res_s = a >> amt_s;
      OP_SRA:   alu_res_s = $unsigned($signed(a) >>> amt_s);
      OP_SLT:   alu_res_s = ($signed(a) < $signed(b)) ? ONE_W : ZERO_W;
      OP_SLTU:  alu_res_s = (a < b) ? ONE_W : ZERO_W;
      OP_INC: begin
        alu_res_s   = inc_s[WIDTH-1:0];
        alu_carry_s = inc_s[WIDTH];
      end
      OP_DEC: begin
        alu_res_s   = dec_s[WIDTH-1:0];
        alu_carry_s = dec_s[WIDTH];
      end
      OP_ROTL:  alu_res_s = rotl_s;
      OP_ROTR:  alu_res_s = rotr_s;
      OP_PASSA: alu_res_s = a;
      OP_PASSB: alu_res_s = b;
`ifdef ALU_SEQ_MULHI_EN
      OP_MULHU: alu_res_s = mulhi_s;
`else
      OP_MULHU: alu_res_s = ZERO_W;
`endif
      default:  alu_res_s = ZERO_W;
    endcase
  end

  // One restoring step: the partial remainder always stays below the divisor,
  // so the subtraction only needs the low WIDTH bits.
  assign rem_shift_s = {rem_r, dvd_r[MSB]};
  assign step_ok_s   = (rem_shift_s >= {1'b0, dvs_r});
  assign rem_sub_s   = rem_shift_s[WIDTH-1:0] - dvs_r;
  assign rem_next_s  = step_ok_s ? rem_sub_s : rem_shift_s[WIDTH-1:0];
  assign quo_next_s  = {dvd_r[WIDTH-2:0], step_ok_s};
  assign div_res_s   = (op_r == OP_REM) ? rem_next_s : quo_next_s;

  // Next-state decode; requests are only looked at in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = div_start_s ? DIV : HOLD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DIV: begin
        if (count_r == CNT_LAST) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = DIV;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register and handshake outputs, registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == HOLD);
      busy_r      <= (state_nxt_s != IDLE);
    end
  end

  // Operand latch, divider iteration and result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_r <= ZERO_W;
      zero_r   <= 1'b0;
      carry_r  <= 1'b0;
      ovf_r    <= 1'b0;
      neg_r    <= 1'b0;
      dbz_r    <= 1'b0;
      dvd_r    <= ZERO_W;
      dvs_r    <= ZERO_W;
      rem_r    <= ZERO_W;
      op_r     <= 5'b00000;
      count_r  <= CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && div_start_s) begin
            dvd_r   <= a;
            dvs_r   <= b;
            op_r    <= opcode;
            rem_r   <= ZERO_W;
            count_r <= CNT_ZERO;
          end else if (in_valid) begin
            result_r <= alu_res_s;
            zero_r   <= (alu_res_s == ZERO_W);
            carry_r  <= alu_carry_s;
            ovf_r    <= alu_ovf_s;
            neg_r    <= alu_res_s[MSB];
            dbz_r    <= alu_dbz_s;
          end
        end
        DIV: begin
          rem_r   <= rem_next_s;
          dvd_r   <= quo_next_s;
          count_r <= count_r + CNT_ONE;
          if (count_r == CNT_LAST) begin
            result_r <= div_res_s;
            zero_r   <= (div_res_s == ZERO_W);
            carry_r  <= 1'b0;
            ovf_r    <= 1'b0;
            neg_r    <= div_res_s[MSB];
            dbz_r    <= 1'b0;
          end
        end
        HOLD: begin
          result_r <= result_r;
        end
        default: begin
          result_r <= result_r;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign busy        = busy_r;
  assign result      = result_r;
  assign zero        = zero_r;
  assign carry_out   = carry_r;
  assign overflow    = ovf_r;
  assign negative    = neg_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH = 16); MULHU expectation follows ALU_SEQ_MULHI_EN.
module tb_alu_seq;

  localparam int W  = 16;
  localparam int NV = 24;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = 16'h0000;
  logic [W-1:0] b = 16'h0000;
  logic [4:0]   opcode = 5'b00000;
  logic         in_ready, out_valid, zero, carry_out, overflow, negative, div_by_zero, busy;
  logic [W-1:0] result;

  int total = 0;
  int bad   = 0;

  logic [4:0]   v_op  [NV];
  logic [W-1:0] v_a   [NV];
  logic [W-1:0] v_b   [NV];
  logic [W-1:0] v_res [NV];
  logic [1:0]   v_cv  [NV];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry_out(carry_out), .overflow(overflow),
    .negative(negative), .div_by_zero(div_by_zero), .busy(busy)
  );

  task automatic issue(input logic [4:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb);
    opcode = op; a = aa; b = bb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      bad++; $display("FAIL reset_handshake got=%b want=001", {out_valid, busy, in_ready});
    end
    total++;
    if ({result, zero, carry_out, overflow, negative, div_by_zero} !== 21'h0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {result, zero, carry_out, overflow, negative, div_by_zero});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++; $display("FAIL reset_release got=%b want=10", {in_ready, out_valid});
    end
  endtask

  task automatic test_add();
    issue(5'b00000, 16'h7FFF, 16'h0001);
    total++;
    if ({out_valid, in_ready} !== 2'b10) begin
      bad++; $display("FAIL add_latency got=%b want=10", {out_valid, in_ready});
    end
    total++;
    if (result !== 16'h8000) begin
      bad++; $display("FAIL add_result got=%h want=8000", result);
    end
    total++;
    if ({zero, carry_out, overflow, negative, div_by_zero} !== 5'b00110) begin
      bad++; $display("FAIL add_flags got=%b want=00110", {zero, carry_out, overflow, negative, div_by_zero});
    end
    release_out();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL add_consume got=%b want=0", out_valid);
    end
  endtask

  task automatic test_alu_ops();
    logic [4:0] expf;
    v_op  = '{5'b00001, 5'b00001, 5'b00010, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
              5'b01010, 5'b01011, 5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b10000, 5'b10001,
              5'b10010, 5'b10011, 5'b10100, 5'b10100, 5'b10101, 5'b10110, 5'b10111, 5'b11111};
    v_a   = '{16'h0000, 16'h8000, 16'h0100, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hF0F0,
              16'hF0F0, 16'h1234, 16'h0001, 16'h0001, 16'h8000, 16'h8000, 16'hFFFF, 16'hFFFF,
              16'hFFFF, 16'h0000, 16'h8001, 16'h1234, 16'h0001, 16'h1234, 16'h1234, 16'hAAAA};
    v_b   = '{16'h0001, 16'h0001, 16'h0101, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00,
              16'hFF00, 16'h0000, 16'h0000, 16'h0013, 16'h000F, 16'h000F, 16'h0001, 16'h0001,
              16'h0000, 16'h0000, 16'h0004, 16'h0010, 16'h0001, 16'h5678, 16'h5678, 16'h5555};
    v_res = '{16'hFFFF, 16'h7FFF, 16'h0100, 16'hF000, 16'hFFF0, 16'h0FF0, 16'h0FFF, 16'h000F,
              16'hF00F, 16'hEDCB, 16'hFFFF, 16'h0008, 16'h0001, 16'hFFFF, 16'h0001, 16'h0000,
              16'h0000, 16'hFFFF, 16'h0018, 16'h1234, 16'h8000, 16'h1234, 16'h5678, 16'h0000};
    v_cv  = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
              2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
              2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    for (int i = 0; i < NV; i++) begin
      issue(v_op[i], v_a[i], v_b[i]);
      expf = {(v_res[i] == 16'h0000), v_cv[i], v_res[i][15], 1'b0};
      total++;
      if (out_valid !== 1'b1) begin
        bad++; $display("FAIL op%0d_valid got=%b want=1", i, out_valid);
      end
      total++;
      if (result !== v_res[i]) begin
        bad++; $display("FAIL op%0d_result opcode=%b got=%h want=%h", i, v_op[i], result, v_res[i]);
      end
      total++;
      if ({zero, carry_out, overflow, negative, div_by_zero} !== expf) begin
        bad++; $display("FAIL op%0d_flags got=%b want=%b", i, {zero, carry_out, overflow, negative, div_by_zero}, expf);
      end
      release_out();
    end
  endtask

  task automatic test_div(input logic [4:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic [W-1:0] expect_res);
    int lat;
    int ready_seen;
    lat = 0;
    ready_seen = 0;
    issue(op, aa, bb);
    for (int k = 1; k <= 40; k++) begin
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
      if (in_ready !== 1'b0 || busy !== 1'b1) ready_seen++;
      @(posedge clk); #1;
    end
    total++;
    if (lat != 17) begin
      bad++; $display("FAIL div_latency op=%b got=%0d want=17", op, lat);
    end
    total++;
    if (ready_seen != 0) begin
      bad++; $display("FAIL div_in_ready cycles_ready=%0d want=0", ready_seen);
    end
    total++;
    if (result !== expect_res) begin
      bad++; $display("FAIL div_result op=%b got=%0d want=%0d", op, result, expect_res);
    end
    total++;
    if ({zero, carry_out, overflow, div_by_zero} !== 4'b0000) begin
      bad++; $display("FAIL div_flags got=%b want=0000", {zero, carry_out, overflow, div_by_zero});
    end
    release_out();
  endtask

  task automatic test_div_zero();
    issue(5'b00011, 16'd5, 16'd0);
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL dbz_latency got=%b want=1", out_valid);
    end
    total++;
    if ({result, zero, div_by_zero} !== {16'h0000, 2'b11}) begin
      bad++; $display("FAIL dbz_result got=%h z=%b dbz=%b want=0 1 1", result, zero, div_by_zero);
    end
    release_out();
  endtask

  task automatic test_backpressure();
    issue(5'b00111, 16'h00FF, 16'h0F0F);
    for (int k = 0; k < 5; k++) begin
      opcode = 5'b00000; a = 16'h0001; b = 16'h0001; in_valid = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({out_valid, in_ready, result, zero, carry_out, overflow, negative, div_by_zero}
          !== {2'b10, 16'h0FF0, 5'b00000}) begin
        bad++; $display("FAIL hold_cycle%0d got v=%b r=%b res=%h want v=1 r=0 res=0ff0", k, out_valid, in_ready, result);
      end
    end
    in_valid = 1'b0;
    opcode = 5'bxxxxx;
    release_out();
    total++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      bad++; $display("FAIL hold_release got=%b want=010", {out_valid, in_ready, busy});
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL hold_no_queue got=%b want=0", out_valid);
    end
  endtask

  task automatic test_reset_mid_div();
    int stale;
    stale = 0;
    issue(5'b00011, 16'hFFFF, 16'h0003);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({out_valid, busy, in_ready, result, div_by_zero} !== {3'b001, 16'h0000, 1'b0}) begin
      bad++; $display("FAIL rst_div got v=%b busy=%b rdy=%b res=%h want 0 0 1 0000", out_valid, busy, in_ready, result);
    end
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) stale++;
    end
    total++;
    if (stale != 0) begin
      bad++; $display("FAIL rst_div_stale got=%0d want=0", stale);
    end
  endtask

  task automatic test_back_to_back();
    int valids;
    int overlap;
    valids = 0;
    overlap = 0;
    out_ready = 1'b1;
    opcode = 5'b10010; a = 16'h0005; b = 16'h0000; in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) valids++;
      if (out_valid === 1'b1 && in_ready === 1'b1) overlap++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    total++;
    if (valids != 3 || overlap != 0) begin
      bad++; $display("FAIL b2b got valids=%0d overlap=%0d want 3 0", valids, overlap);
    end
    total++;
    if (result !== 16'h0006) begin
      bad++; $display("FAIL b2b_result got=%h want=0006", result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mulhu();
    logic [W-1:0] exp_res;
`ifdef ALU_SEQ_MULHI_EN
    exp_res = 16'hFFFE;
`else
    exp_res = 16'h0000;
`endif
    issue(5'b11000, 16'hFFFF, 16'hFFFF);
    total++;
    if ({out_valid, result, zero} !== {1'b1, exp_res, (exp_res == 16'h0000)}) begin
      bad++; $display("FAIL mulhu got v=%b res=%h z=%b want v=1 res=%h", out_valid, result, zero, exp_res);
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_div(5'b00011, 16'd1000, 16'd7, 16'd142);
    test_div(5'b00100, 16'd1000, 16'd7, 16'd6);
    test_div_zero();
    test_backpressure();
    test_reset_mid_div();
    test_back_to_back();
    test_mulhu();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
